// File: rtl/stream_mux_rr_if.sv
// Stream mux handshake bundle: mode/sel control, N input channels and one output stream.
// The slave modport is the mux side; the master modport is the environment side.
interface stream_mux_rr_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SW = $clog2(N);

  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_chan;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux with one registered output stage, fixed or round-robin select.
// Round-robin mode and its pointer are only built when STREAM_MUX_RR_MODE_EN is defined.
module stream_mux_rr #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic            clk,
  input logic            rst,
  stream_mux_rr_if.slave bus
);
  localparam int unsigned SW = $clog2(N);

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_chan_q, out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic          load_en;
  logic          gnt_vld;
  logic [SW-1:0] gnt;
  logic [N-1:0]  rdy;

`ifdef STREAM_MUX_RR_MODE_EN
  logic [SW-1:0] ptr_q, ptr_d;
  int unsigned   idx;
`endif

  always_comb begin
    load_en = !rst && (!out_valid_q || bus.out_ready);
    gnt_vld = 1'b0;
    gnt     = bus.sel;
    if (32'(bus.sel) < N) gnt_vld = bus.in_valid[bus.sel];
`ifdef STREAM_MUX_RR_MODE_EN
    idx   = 0;
    ptr_d = ptr_q;
    if (bus.mode) begin
      gnt_vld = 1'b0;
      gnt     = '0;
      // first valid channel at or after ptr, wrapping modulo N
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr_q) + k) % N;
        if (!gnt_vld && bus.in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SW'(idx);
        end
      end
      if (load_en && gnt_vld) ptr_d = (32'(gnt) == N - 1) ? '0 : gnt + 1'b1;
    end
`endif
  end

  always_comb begin
    rdy         = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load_en) begin
      if (gnt_vld) begin
        rdy[gnt]    = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = bus.in_data[32'(gnt) * W +: W];
        out_chan_d  = gnt;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
`ifdef STREAM_MUX_RR_MODE_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
`ifdef STREAM_MUX_RR_MODE_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4, W=8): directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the mux.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;
`ifdef STREAM_MUX_RR_MODE_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  // model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;

  stream_mux_rr_if #(.N(N), .W(W)) bus ();
  stream_mux_rr #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // nearest valid channel in circular distance from ptr, or sel in fixed mode
  function automatic void ref_grant(input logic md, input logic [1:0] s, input logic [3:0] v,
                                    input int ptr, output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (RR && md) begin
      int best;
      best = N;
      for (int i = 0; i < N; i++)
        if (v[i] && ((i - ptr + N) % N) < best) begin
          best = (i - ptr + N) % N;
          g    = i;
        end
      ok = (best < N);
    end else begin
      ok = v[s];
      g  = int'(s);
    end
  endfunction

  task automatic drive(input bit md, input int s, input logic [3:0] v,
                       input logic [31:0] d, input bit ordy);
    bus.mode      = md;
    bus.sel       = 2'(s);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // called just after a negedge with inputs applied; returns at the next negedge
  task automatic step();
    bit         ok;
    int         g;
    bit         load;
    logic [3:0] exp_rdy;
    #1;
    ref_grant(bus.mode, bus.sel, bus.in_valid, m_ptr, ok, g);
    load    = !m_valid || bus.out_ready;
    exp_rdy = (!rst && load && ok) ? 4'(1 << g) : 4'b0000;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("out_data", 64'(bus.out_data), 64'(m_data));
    check("out_chan", 64'(bus.out_chan), 64'(m_chan));
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = 0;
    end else if (load) begin
      if (ok) begin
        m_valid = 1'b1;
        m_data  = bus.in_data[g*W +: W];
        m_chan  = g;
        if (RR && bus.mode) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 4'hF, 32'hDEADBEEF, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_out_chan", 64'(bus.out_chan), 64'h0);
    step();
    rst = 1'b0;

    // fixed select of channel 2
    drive(1'b0, 2, 4'b0100, 32'h00A50000, 1'b1);
    #1 check("fix_rdy", 64'(bus.in_ready), 64'h4);
    step();
    check("fix_valid", 64'(bus.out_valid), 64'h1);
    check("fix_data", 64'(bus.out_data), 64'hA5);
    check("fix_chan", 64'(bus.out_chan), 64'h2);

    // stall holds the word while sel moves
    drive(1'b0, 1, 4'b0010, 32'h00003C00, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, (k == 0) ? 1 : 3, 4'b1010, 32'h77003C00, 1'b0);
      #1 check("stall_rdy", 64'(bus.in_ready), 64'h0);
      step();
      check("stall_data", 64'(bus.out_data), 64'h3C);
      check("stall_chan", 64'(bus.out_chan), 64'h1);
      check("stall_valid", 64'(bus.out_valid), 64'h1);
    end
    drive(1'b0, 3, 4'b1010, 32'h77003C00, 1'b1);
    step();
    check("unstall_data", 64'(bus.out_data), 64'h77);
    check("unstall_chan", 64'(bus.out_chan), 64'h3);

`ifdef STREAM_MUX_RR_MODE_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 0, 4'hF, 32'h44332211, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_seq_chan", 64'(bus.out_chan), 64'(k % N));
    end
    step();
    check("rr_to_ptr3", 64'(bus.out_chan), 64'h2);
    drive(1'b1, 0, 4'b0011, 32'h44332211, 1'b1);
    step();
    check("rr_wrap_chan", 64'(bus.out_chan), 64'h0);
    step();
    check("rr_ptr1_chan", 64'(bus.out_chan), 64'h1);

    // reset while a word is held discards it and restarts the scan at 0
    drive(1'b1, 0, 4'hF, 32'h44332211, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", 64'(bus.out_valid), 64'h0);
    check("rst_mid_data", 64'(bus.out_data), 64'h0);
    check("rst_mid_chan", 64'(bus.out_chan), 64'h0);
    step();
    check("rst_rr_first", 64'(bus.out_chan), 64'h0);
`else
    drive(1'b1, 1, 4'hF, 32'h44332211, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("nomode_chan", 64'(bus.out_chan), 64'h1);
      check("nomode_data", 64'(bus.out_data), 64'h22);
    end
`endif

    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 4'($urandom),
            $urandom, ($urandom_range(0, 9) < 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..64.
REQ-003 Derived constant SW = $clog2(N): select and channel-tag width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-007 sel  input  SW  channel index used in fixed mode.
REQ-008 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready; combinational.
REQ-011 out_data  output  W  registered data.
REQ-012 out_valid  output  1  registered valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_chan  output  SW  registered index of the source channel of out_data.

Function
REQ-015 The block SHALL have one output register stage; load_en = !out_valid || out_ready.
REQ-016 Fixed mode: grant = sel when in_valid[sel] = 1; otherwise there is no grant.
REQ-017 Round-robin mode: grant = first i with in_valid[i] = 1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N); no grant when in_valid = 0.
REQ-018 in_ready[i] SHALL be 1 only when load_en = 1 and i is the granted channel; it is 0 for all other channels.
REQ-019 Transfer on channel g: on the next edge, out_data <= in_data[g], out_chan <= g, out_valid <= 1.
REQ-020 load_en = 1 with no grant: out_valid <= 0 on the next edge; out_data and out_chan hold.
REQ-021 out_valid = 1 and out_ready = 0: out_data, out_chan and out_valid SHALL hold, and all in_ready SHALL be 0.
REQ-022 Latency SHALL be one cycle from input transfer to out_valid; sustained throughput is one word per cycle when out_ready = 1.
REQ-023 ptr (SW bits) SHALL update to (g+1) mod N only on a round-robin transfer; it wraps from N-1 to 0.
REQ-024 ptr SHALL hold in fixed mode, so a switch back to round-robin resumes from the stored pointer.
REQ-025 Changes to sel or mode while output is stalled SHALL NOT affect the held word; they take effect at the next load_en.
REQ-026 A channel whose in_valid stays high while it is not granted SHALL NOT lose data; it waits without a transfer.

Reset
REQ-027 While rst = 1: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0, all in_ready = 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; the first grant after reset follows REQ-016/017 with ptr = 0.

Configuration
REQ-029 Macro STREAM_MUX_RR_MODE_EN: when defined, round-robin logic and ptr are built and REQ-017/023/024 apply.
REQ-030 When STREAM_MUX_RR_MODE_EN is not defined, the mode input SHALL be ignored, the block operates in fixed mode only, and there is no ptr register.

Verification (N=4, W=8, macro defined unless stated)
REQ-031 Fixed mode, sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_chan=2; in_ready=4'b0100 at the transfer cycle.
REQ-032 Round-robin, all valid, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1; ptr wraps 3 -> 0.
REQ-033 Hold word 8'h3C from channel 1 with out_ready=0 for 3 cycles while sel changes 1 -> 3 -> out_data stays 3C, out_chan stays 1, in_ready=0; after out_ready returns to 1, the next word comes from channel 3.
REQ-034 Round-robin, ptr=3, in_valid=4'b0011 -> grant is channel 0, then ptr=1.
REQ-035 rst pulsed for one cycle while out_valid=1 -> out_valid=0, out_data=0, out_chan=0 in the following cycle; the next round-robin grant starts scanning from 0.
REQ-036 Macro undefined, mode=1, sel=1, all channels valid -> every transfer comes from channel 1.
